// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch program counter and sequences IF through BOOT/RUN/STALL/FLUSH/HALT.
// Build option PC_HALT_ON_WRAP_EN: incrementing from PC_MAX halts instead of wrapping to RESET_PC.
module pc_sequencer #(
    parameter int PC_W      = 4,
    parameter int PC_MAX    = 15,
    parameter int RESET_PC  = 0,
    parameter int FLUSH_CYC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic            halt_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_next_o,
    output logic            if_valid_o,
    output logic            flush_o,
    output logic [2:0]      state_o
);

    localparam logic [2:0] BOOT  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] STALL = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;

    localparam logic [PC_W-1:0] PC_LAST    = PC_W'(PC_MAX);
    localparam logic [PC_W-1:0] PC_INIT    = PC_W'(RESET_PC);
    localparam logic [1:0]      FLUSH_LAST = 2'(FLUSH_CYC);

`ifdef PC_HALT_ON_WRAP_EN
    localparam bit HALT_ON_WRAP = 1'b1;
`else
    localparam bit HALT_ON_WRAP = 1'b0;
`endif

    // Targets above PC_LAST are legal; their increment rolls over modulo 2^PC_W.
    function automatic logic [PC_W-1:0] wrap_incr(input logic [PC_W-1:0] pc);
        return (pc == PC_LAST) ? PC_INIT : pc + PC_W'(1);
    endfunction

    logic [2:0]      state;
    logic [2:0]      state_d;
    logic [PC_W-1:0] pc_d;
    logic [1:0]      cnt;
    logic [1:0]      cnt_d;
    logic            redirect;
    logic [PC_W-1:0] target;

    // Branch wins over a simultaneous jump.
    assign redirect  = branch_taken_i | jump_i;
    assign target    = branch_taken_i ? branch_target_i : jump_target_i;
    assign pc_next_o = wrap_incr(pc_o);
    assign state_o   = state;

    always_comb begin
        state_d = state;
        pc_d    = pc_o;
        cnt_d   = cnt;
        case (state)
            BOOT: state_d = RUN;
            RUN, STALL: begin
                if (halt_i) begin
                    state_d = HALT;
                end else if (redirect) begin
                    pc_d    = target;
                    cnt_d   = 2'd1;
                    state_d = FLUSH;
                end else if (stall_i) begin
                    state_d = STALL;
                end else if (HALT_ON_WRAP && (pc_o == PC_LAST)) begin
                    state_d = HALT;
                end else begin
                    pc_d    = pc_next_o;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // cnt holds the number of bubble cycles already presented.
                if (halt_i) begin
                    state_d = HALT;
                end else if (redirect) begin
                    pc_d  = target;
                    cnt_d = 2'd1;
                end else if (cnt >= FLUSH_LAST) begin
                    cnt_d   = 2'd0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt + 2'd1;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    // Outputs are registered from the next state so they line up with pc_o.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            pc_o       <= PC_INIT;
            cnt        <= 2'd0;
            if_valid_o <= 1'b0;
            flush_o    <= 1'b0;
        end else begin
            state      <= state_d;
            pc_o       <= pc_d;
            cnt        <= cnt_d;
            if_valid_o <= (state_d == RUN);
            flush_o    <= (state_d == FLUSH);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (default-like and a narrow-range variant) against a rule-level model.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stall_i = 1'b0, branch_taken_i = 1'b0, jump_i = 1'b0, halt_i = 1'b0;
    logic [3:0] branch_target_i = 4'd0, jump_target_i = 4'd0;

    logic [3:0] pc_a, pcn_a, pc_b, pcn_b;
    logic       v_a, f_a, v_b, f_b;
    logic [2:0] st_a, st_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(4), .PC_MAX(15), .RESET_PC(0), .FLUSH_CYC(2)) dut_a (
        .clk(clk), .reset(reset), .stall_i(stall_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
        .halt_i(halt_i), .pc_o(pc_a), .pc_next_o(pcn_a), .if_valid_o(v_a), .flush_o(f_a),
        .state_o(st_a));

    pc_sequencer #(.PC_W(4), .PC_MAX(11), .RESET_PC(2), .FLUSH_CYC(1)) dut_b (
        .clk(clk), .reset(reset), .stall_i(stall_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
        .halt_i(halt_i), .pc_o(pc_b), .pc_next_o(pcn_b), .if_valid_o(v_b), .flush_o(f_b),
        .state_o(st_b));

    // Reference model: per-instance mode, PC and remaining bubble count.
    localparam int M_BOOT = 0, M_RUN = 1, M_STALL = 2, M_FLUSH = 3, M_HALT = 4;
    int p_max[2] = '{15, 11};
    int p_rst[2] = '{0, 2};
    int p_fc[2]  = '{2, 1};
    int m_st[2], m_pc[2], m_bub[2];
`ifdef PC_HALT_ON_WRAP_EN
    bit wrap_halt = 1'b1;
`else
    bit wrap_halt = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_next(input int i);
        if (m_pc[i] == p_max[i]) return p_rst[i];
        return (m_pc[i] + 1) % 16;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = M_BOOT; m_pc[i] = p_rst[i]; m_bub[i] = 0;
        end
    endfunction

    function automatic void model_step();
        int tgt;
        bit rd;
        rd  = branch_taken_i || jump_i;
        tgt = branch_taken_i ? int'(branch_target_i) : int'(jump_target_i);
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] == M_BOOT) m_st[i] = M_RUN;
            else if (m_st[i] == M_HALT) m_st[i] = M_HALT;
            else if (halt_i) m_st[i] = M_HALT;
            else if (rd) begin
                m_pc[i] = tgt; m_st[i] = M_FLUSH; m_bub[i] = p_fc[i];
            end else if (m_st[i] == M_FLUSH) begin
                m_bub[i]--;
                if (m_bub[i] == 0) m_st[i] = M_RUN;
            end else if (stall_i) m_st[i] = M_STALL;
            else if (wrap_halt && m_pc[i] == p_max[i]) m_st[i] = M_HALT;
            else begin
                m_pc[i] = m_next(i); m_st[i] = M_RUN;
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ":a.pc"},    32'(pc_a),  32'(m_pc[0]));
        check({tag, ":a.pcn"},   32'(pcn_a), 32'(m_next(0)));
        check({tag, ":a.valid"}, 32'(v_a),   32'(m_st[0] == M_RUN));
        check({tag, ":a.flush"}, 32'(f_a),   32'(m_st[0] == M_FLUSH));
        check({tag, ":a.state"}, 32'(st_a),  32'(m_st[0]));
        check({tag, ":b.pc"},    32'(pc_b),  32'(m_pc[1]));
        check({tag, ":b.pcn"},   32'(pcn_b), 32'(m_next(1)));
        check({tag, ":b.valid"}, 32'(v_b),   32'(m_st[1] == M_RUN));
        check({tag, ":b.flush"}, 32'(f_b),   32'(m_st[1] == M_FLUSH));
        check({tag, ":b.state"}, 32'(st_b),  32'(m_st[1]));
    endtask

    task automatic clear_inputs();
        stall_i = 0; branch_taken_i = 0; jump_i = 0; halt_i = 0;
        branch_target_i = 0; jump_target_i = 0;
    endtask

    // One clock: model advances with the DUT, compare at the following falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    // Async reset asserted away from the clock edge, released on a falling edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all("reset_async");
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1 compare_all("reset_release");
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        check("boot_pc", 32'(pc_a), 32'd0);
        check("boot_valid", 32'(v_a), 32'd0);

        // Free run across the wrap point.
        for (int k = 1; k <= 16; k++) tick("run");
        check("run_pc15", 32'(pc_a), 32'd15);
        check("run_valid15", 32'(v_a), 32'd1);
        tick("wrap");
`ifdef PC_HALT_ON_WRAP_EN
        check("wrap_halt_state", 32'(st_a), 32'd4);
        check("wrap_halt_pc", 32'(pc_a), 32'd15);
`else
        check("wrap_pc", 32'(pc_a), 32'd0);
        check("wrap_valid", 32'(v_a), 32'd1);
`endif
        for (int k = 0; k < 3; k++) tick("post_wrap");

        // Stall for 3 cycles at pc 5.
        do_reset();
        for (int k = 0; k < 6; k++) tick("to5");
        check("stall_at5", 32'(pc_a), 32'd5);
        stall_i = 1;
        for (int k = 0; k < 3; k++) begin
            tick("stall");
            check("stall_pc", 32'(pc_a), 32'd5);
            check("stall_valid", 32'(v_a), 32'd0);
        end
        stall_i = 0;
        tick("stall_exit");
        check("stall_exit_pc", 32'(pc_a), 32'd6);

        // Branch to 0xA at pc 3 with two bubbles.
        do_reset();
        for (int k = 0; k < 4; k++) tick("to3");
        branch_taken_i = 1; branch_target_i = 4'hA;
        tick("br");
        clear_inputs();
        check("br_flush1", 32'(f_a), 32'd1);
        check("br_pc1", 32'(pc_a), 32'hA);
        tick("br_bubble2");
        check("br_flush2", 32'(f_a), 32'd1);
        tick("br_run");
        check("br_run_pc", 32'(pc_a), 32'hA);
        check("br_run_flush", 32'(f_a), 32'd0);
        tick("br_next");
        check("br_next_pc", 32'(pc_a), 32'hB);

        // Branch, jump and stall together.
        stall_i = 1; branch_taken_i = 1; branch_target_i = 4'd7; jump_i = 1; jump_target_i = 4'd2;
        tick("prio");
        check("prio_pc", 32'(pc_a), 32'd7);
        check("prio_state", 32'(st_a), 32'd3);
        clear_inputs();
        for (int k = 0; k < 4; k++) tick("prio_after");

        // Halt at pc 9, hold for 20 cycles, then reset.
        do_reset();
        for (int k = 0; k < 10; k++) tick("to9");
        halt_i = 1;
        tick("halt");
        halt_i = 0;
        for (int k = 0; k < 20; k++) tick("halted");
        check("halt_pc", 32'(pc_a), 32'd9);
        check("halt_valid", 32'(v_a), 32'd0);
        do_reset();
        check("halt_reset_state", 32'(st_a), 32'd0);

        // Randomised traffic with occasional mid-cycle resets.
        for (int n = 0; n < 3000; n++) begin
            stall_i         = ($urandom_range(0, 3) == 0);
            branch_taken_i  = ($urandom_range(0, 7) == 0);
            jump_i          = ($urandom_range(0, 7) == 0);
            halt_i          = ($urandom_range(0, 199) == 0);
            branch_target_i = 4'($urandom_range(0, 15));
            jump_target_i   = 4'($urandom_range(0, 15));
            tick("rand");
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
